pe_top: RTL and testbench
=========================

# pe_top

Single processing element (PE) of the coarse-grained reconfigurable array. It receives a 33-bit configuration stream: one instruction word followed by 32-bit constant words. It then consumes 36-bit data tokens from up to three neighbour PEs and computes one ALU result per firing. Results go out on a registered output port. Flow control uses per-link valid/ready backpressure, and every link is flop-isolated so PEs can be wired in cycles without combinational loops.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- PE_Inport0..PE_Inport2  in  36 each  neighbour tokens: [35] valid, [34] last, [33:32] tag (ignored), [31:0] data.
- PE_Bus_Port0  in  4  bus control; bit0 = global hold (1 = no firing); bits 3:1 ignored.
- Post_PE_Bp0..Post_PE_Bp7  in  1 each  ready from consumers; 1 = can accept; unused ones tied 1.
- PE_Configure_Inport  in  33  [32] cfg valid, [31:0] payload.
- PE_Outport0  out  36  result token, same format as inputs.
- Pre_PE_Bp0..Pre_PE_Bp2  out  1 each  ready to the producer on inport i.

## Operation
- Instruction word fields:
  - [31:25] reserved.
  - [24:22] srcA.
  - [21] useB.
  - [20:16] shamt.
  - [15:13] srcB.
  - [12:9] opcode.
  - [8:0] reserved, ignored.
- Source encoding: 0 = constant register; 1/2/3 = inport0/1/2; 4–7 = constant register.
- Config capture:
  - A word is captured when [32]=1 and the payload differs from the last captured word, or no word has been captured since reset.
  - The first capture after reset is the instruction. Every later capture loads the 32-bit constant register.
  - A held word is taken once. Re-sending an identical constant is a no-op.
- States: WAIT_INSTR → WAIT_CONST → RUN. The PE fires only in RUN. A new instruction requires reset.
- Input buffering: each inport feeds a 2-entry FIFO. A token is pushed when [35]=1 and Pre_PE_Bp_i=1. Pre_PE_Bp_i = (FIFO count != 2), driven from a register.
- Fire condition, all of:
  - state is RUN;
  - PE_Bus_Port0[0]=0;
  - every referenced inport FIFO is non-empty (srcA, plus srcB if useB=1);
  - the output can accept (!out_valid or all Post ready).
- On fire: pop each referenced FIFO once. If srcA==srcB, pop once and use the value for both operands.
- Opcodes (32-bit, wrap on overflow):
  - 0 ADD, 1 SUB (A−B), 2 MUL (low 32 bits), 3 AND, 4 OR, 5 XOR;
  - 6 SHL A<<shamt, 7 SRL, 8 SRA;
  - 9 PASS A;
  - 10 MIN signed, 11 MAX signed;
  - 12 EQ (1/0), 13 LT signed (1/0);
  - 14–15 PASS A.
- Operand B: when useB=0, B = constant register for binary ops.
- Output token: [35]=1, [34] = OR of the consumed operands' last flags (0 for constant operands), [33:32]=0, [31:0] = result.
- Output consumption: consumed when out_valid and all eight Post_PE_Bp are 1. If consumed and not refired in the same cycle, PE_Outport0 becomes all zero.

## Timing
- Reset values:
  - PE_Outport0 = 0; Pre_PE_Bp0..2 = 1.
  - FIFOs empty, state WAIT_INSTR, constant register 0.
- Latency: a token pushed at edge N fires at edge N+1 and is visible on PE_Outport0 after edge N+1 (2 cycles from the producer's output).
- Throughput: one result per cycle when sources and consumers are continuously ready.
- Simultaneous push and pop on a FIFO: count is unchanged. A full FIFO still deasserts ready for that cycle.
- Reset asserted mid-operation: everything clears immediately, including in-flight tokens and configuration.
- Constant update in RUN: affects firings from the next edge onward.

## Configuration
- PE_MUL_EN defined: opcode 2 uses the 32×32 multiplier.
- PE_MUL_EN undefined: no multiplier is built and opcode 2 returns result 0 (token still emitted).

## Structure
- Package pe_pkg: opcode enum, source-select constants, instruction field positions, token bit positions (VALID=35, LAST=34).
- Sub-module pe_in_fifo: the 2-entry, 36-bit FIFO with registered ready, instantiated three times.

## Test plan
- Config: instruction srcA=1, useB=1, srcB=0 (const), op ADD; then constant 8. Inport0 token 5 → PE_Outport0 = {1,0,00,13} two cycles later.
- Backpressure: Post_PE_Bp3=0, feed 3 tokens → output holds the first; Pre_PE_Bp0 drops after FIFO fill; no loss once Bp3 returns to 1.
- Two inputs: SUB inport0−inport1; tokens 20 and 7 arriving one cycle apart → 13 emitted only after both present.
- Held config word: identical constant held 5 cycles → captured once. A new value 12 → next result uses 12.
- PE_Bus_Port0[0]=1 → no firing, FIFOs fill to 2. Release → results drain in order.
- Reset mid-stream → outputs zero, Pre_PE_Bp=1, state WAIT_INSTR. Tokens are ignored until reconfiguration.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the CGRA processing element: opcodes, FSM states,
// source-select encodings, instruction field positions and token bit layout.
package pe_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_SHL    = 4'd6,
        OP_SRL    = 4'd7,
        OP_SRA    = 4'd8,
        OP_PASS   = 4'd9,
        OP_MIN    = 4'd10,
        OP_MAX    = 4'd11,
        OP_EQ     = 4'd12,
        OP_LT     = 4'd13,
        OP_PASS14 = 4'd14,
        OP_PASS15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_WAIT_INSTR = 2'd0,
        ST_WAIT_CONST = 2'd1,
        ST_RUN        = 2'd2
    } state_e;

    // Source selects; codes 0 and 4..7 all mean the constant register.
    localparam logic [2:0] SRC_CONST = 3'd0;
    localparam logic [2:0] SRC_IN0   = 3'd1;
    localparam logic [2:0] SRC_IN1   = 3'd2;
    localparam logic [2:0] SRC_IN2   = 3'd3;

    localparam int INSTR_SRCA_LSB  = 22;
    localparam int INSTR_USEB      = 21;
    localparam int INSTR_SHAMT_LSB = 16;
    localparam int INSTR_SRCB_LSB  = 13;
    localparam int INSTR_OP_LSB    = 9;

    localparam int TOK_VALID   = 35;
    localparam int TOK_LAST    = 34;
    localparam int TOK_TAG_LSB = 32;
    localparam int CFG_VALID   = 32;

    typedef struct packed {
        logic [2:0] src_a;
        logic       use_b;
        logic [4:0] shamt;
        logic [2:0] src_b;
        op_e        op;
    } instr_t;

    // One-hot mask of the inport FIFO a source select reads (zero for constant).
    function automatic logic [2:0] src_mask(input logic [2:0] src);
        logic [2:0] m;
        case (src)
            SRC_IN0: m = 3'b001;
            SRC_IN1: m = 3'b010;
            SRC_IN2: m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Operand value for a source select given the constant and FIFO heads.
    function automatic logic [31:0] sel_operand(input logic [2:0] src, input logic [31:0] k,
                                                input logic [31:0] d0, input logic [31:0] d1,
                                                input logic [31:0] d2);
        logic [31:0] v;
        case (src)
            SRC_IN0: v = d0;
            SRC_IN1: v = d1;
            SRC_IN2: v = d2;
            default: v = k;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pe_in_fifo.sv
// Two-entry input FIFO for one neighbour link. Stores {last, data}; the tag
// is dropped. Ready to the producer is registered so PE rings have no
// combinational path through the link.
module pe_in_fifo
    import pe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [35:0] in_tok,
    input  logic        pop,
    output logic        ready,
    output logic        nonempty,
    output logic [32:0] head
);

    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        ready_q, ready_d;
    logic        push_s, pop_s;
    logic        unused_s;

    assign unused_s = ^in_tok[TOK_TAG_LSB +: 2];

    // Next-state for storage, pointers, occupancy and registered ready.
    always_comb begin
        push_s   = in_tok[TOK_VALID] && ready_q;
        pop_s    = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {in_tok[TOK_LAST], in_tok[31:0]};
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + 2'd1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
        ready_d = (count_d != 2'd2);
    end

    // State registers; reset empties the FIFO and opens the link.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 33'd0;
            mem_q[1] <= 33'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign nonempty = (count_q != 2'd0);
    assign head     = mem_q[rd_ptr_q];

endmodule

// File: rtl/pe_top.sv
// CGRA processing element: config capture FSM, three buffered inports, one
// ALU firing per cycle, registered output token.
// Optional macro PE_MUL_EN builds the 32x32 multiplier for opcode 2;
// without it opcode 2 yields 0.
module pe_top
    import pe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [35:0] PE_Inport0,
    input  logic [35:0] PE_Inport1,
    input  logic [35:0] PE_Inport2,
    input  logic [3:0]  PE_Bus_Port0,
    input  logic        Post_PE_Bp0,
    input  logic        Post_PE_Bp1,
    input  logic        Post_PE_Bp2,
    input  logic        Post_PE_Bp3,
    input  logic        Post_PE_Bp4,
    input  logic        Post_PE_Bp5,
    input  logic        Post_PE_Bp6,
    input  logic        Post_PE_Bp7,
    input  logic [32:0] PE_Configure_Inport,
    output logic [35:0] PE_Outport0,
    output logic        Pre_PE_Bp0,
    output logic        Pre_PE_Bp1,
    output logic        Pre_PE_Bp2
);

    logic [35:0] in_tok_s [3];
    logic [32:0] head_s [3];
    logic [2:0]  ready_s, nonempty_s, pop_s, need_s;
    logic        post_all_s, fire_s, cfg_take_s, last_s, unused_s;
    logic [31:0] op_a_s, op_b_s, alu_s, cfg_word_s;

    state_e      state_q, state_d;
    instr_t      instr_q, instr_d;
    logic [31:0] const_q, const_d;
    logic [31:0] cfg_last_q, cfg_last_d;
    logic        cfg_seen_q, cfg_seen_d;
    logic [35:0] out_q, out_d;

    assign in_tok_s[0] = PE_Inport0;
    assign in_tok_s[1] = PE_Inport1;
    assign in_tok_s[2] = PE_Inport2;
    assign unused_s    = ^PE_Bus_Port0[3:1];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fifo
            pe_in_fifo u_fifo (
                .clk      (clk),
                .rst_n    (reset),
                .in_tok   (in_tok_s[gi]),
                .pop      (pop_s[gi]),
                .ready    (ready_s[gi]),
                .nonempty (nonempty_s[gi]),
                .head     (head_s[gi])
            );
        end
    endgenerate

    // Operand routing, fire decision and FIFO pops.
    always_comb begin
        post_all_s = &{Post_PE_Bp7, Post_PE_Bp6, Post_PE_Bp5, Post_PE_Bp4,
                       Post_PE_Bp3, Post_PE_Bp2, Post_PE_Bp1, Post_PE_Bp0};
        // OR of the masks makes srcA==srcB pop that FIFO only once.
        need_s = src_mask(instr_q.src_a) | (instr_q.use_b ? src_mask(instr_q.src_b) : 3'b000);
        fire_s = (state_q == ST_RUN) && !PE_Bus_Port0[0] && ((need_s & ~nonempty_s) == 3'b000)
                 && (!out_q[TOK_VALID] || post_all_s);
        pop_s  = fire_s ? need_s : 3'b000;
        op_a_s = sel_operand(instr_q.src_a, const_q, head_s[0][31:0], head_s[1][31:0], head_s[2][31:0]);
        if (instr_q.use_b) begin
            op_b_s = sel_operand(instr_q.src_b, const_q, head_s[0][31:0], head_s[1][31:0], head_s[2][31:0]);
        end else begin
            op_b_s = const_q;
        end
        last_s = |(need_s & {head_s[2][32], head_s[1][32], head_s[0][32]});
    end

    // ALU: one 32-bit result per firing, wrapping arithmetic.
    always_comb begin
        alu_s = 32'd0;
        case (instr_q.op)
            OP_ADD:  alu_s = op_a_s + op_b_s;
            OP_SUB:  alu_s = op_a_s - op_b_s;
`ifdef PE_MUL_EN
            OP_MUL:  alu_s = op_a_s * op_b_s;
`else
            OP_MUL:  alu_s = 32'd0;
`endif
            OP_AND:  alu_s = op_a_s & op_b_s;
            OP_OR:   alu_s = op_a_s | op_b_s;
            OP_XOR:  alu_s = op_a_s ^ op_b_s;
            OP_SHL:  alu_s = op_a_s << instr_q.shamt;
            OP_SRL:  alu_s = op_a_s >> instr_q.shamt;
            OP_SRA:  alu_s = $unsigned($signed(op_a_s) >>> instr_q.shamt);
            OP_MIN:  alu_s = ($signed(op_a_s) < $signed(op_b_s)) ? op_a_s : op_b_s;
            OP_MAX:  alu_s = ($signed(op_a_s) > $signed(op_b_s)) ? op_a_s : op_b_s;
            OP_EQ:   alu_s = {31'd0, (op_a_s == op_b_s)};
            OP_LT:   alu_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
            default: alu_s = op_a_s;
        endcase
    end

    // Config capture FSM next-state and output token next-state.
    always_comb begin
        cfg_word_s = PE_Configure_Inport[31:0];
        cfg_take_s = PE_Configure_Inport[CFG_VALID] && (!cfg_seen_q || (cfg_word_s != cfg_last_q));
        state_d    = state_q;
        instr_d    = instr_q;
        const_d    = const_q;
        cfg_last_d = cfg_last_q;
        cfg_seen_d = cfg_seen_q;
        if (cfg_take_s) begin
            cfg_seen_d = 1'b1;
            cfg_last_d = cfg_word_s;
            case (state_q)
                ST_WAIT_INSTR: begin
                    instr_d.src_a = cfg_word_s[INSTR_SRCA_LSB +: 3];
                    instr_d.use_b = cfg_word_s[INSTR_USEB];
                    instr_d.shamt = cfg_word_s[INSTR_SHAMT_LSB +: 5];
                    instr_d.src_b = cfg_word_s[INSTR_SRCB_LSB +: 3];
                    instr_d.op    = op_e'(cfg_word_s[INSTR_OP_LSB +: 4]);
                    state_d       = ST_WAIT_CONST;
                end
                ST_WAIT_CONST: begin
                    const_d = cfg_word_s;
                    state_d = ST_RUN;
                end
                default: begin
                    const_d = cfg_word_s;
                    state_d = ST_RUN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        if (fire_s) begin
            out_d = {1'b1, last_s, 2'b00, alu_s};
        end else if (out_q[TOK_VALID] && post_all_s) begin
            out_d = 36'd0;
        end else begin
            out_d = out_q;
        end
    end

    // All PE state; reset drops configuration and any in-flight result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WAIT_INSTR;
            instr_q    <= '0;
            const_q    <= 32'd0;
            cfg_last_q <= 32'd0;
            cfg_seen_q <= 1'b0;
            out_q      <= 36'd0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            const_q    <= const_d;
            cfg_last_q <= cfg_last_d;
            cfg_seen_q <= cfg_seen_d;
            out_q      <= out_d;
        end
    end

    assign PE_Outport0 = out_q;
    assign Pre_PE_Bp0  = ready_s[0];
    assign Pre_PE_Bp1  = ready_s[1];
    assign Pre_PE_Bp2  = ready_s[2];

endmodule

// File: tb/tb_pe_top.sv
// Directed, table-driven bench for pe_top plus hand-written multi-cycle cases.
module tb_pe_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [35:0] in0, in1, in2;
    logic [3:0]  bus;
    logic [7:0]  post;
    logic [32:0] cfg;
    logic [35:0] out;
    logic        pre0, pre1, pre2;
    int          checks = 0;
    int          errors = 0;

`ifdef PE_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'h0001_0000;
`else
    localparam logic [31:0] MUL_EXP = 32'd0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  sa;
        logic        ub;
        logic [2:0]  sb;
        logic [4:0]  sh;
        logic [31:0] k;
        logic [31:0] a;
        logic        la;
        logic        sendb;
        logic [31:0] b;
        logic        lb;
        logic [31:0] ed;
        logic        el;
    } vec_t;

    vec_t vt [21];

    always #5 clk = ~clk;

    pe_top dut (
        .clk(clk), .reset(reset),
        .PE_Inport0(in0), .PE_Inport1(in1), .PE_Inport2(in2),
        .PE_Bus_Port0(bus),
        .Post_PE_Bp0(post[0]), .Post_PE_Bp1(post[1]), .Post_PE_Bp2(post[2]), .Post_PE_Bp3(post[3]),
        .Post_PE_Bp4(post[4]), .Post_PE_Bp5(post[5]), .Post_PE_Bp6(post[6]), .Post_PE_Bp7(post[7]),
        .PE_Configure_Inport(cfg),
        .PE_Outport0(out),
        .Pre_PE_Bp0(pre0), .Pre_PE_Bp1(pre1), .Pre_PE_Bp2(pre2)
    );

    function automatic logic [31:0] mk(input logic [2:0] sa, input logic ub, input logic [4:0] sh,
                                       input logic [2:0] sb, input logic [3:0] op);
        return {7'd0, sa, ub, sh, sb, op, 9'd0};
    endfunction

    function automatic logic [35:0] tok(input logic l, input logic [31:0] d);
        return {1'b1, l, 2'b00, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in0 = 36'd0; in1 = 36'd0; in2 = 36'd0;
        bus = 4'd0; post = 8'hFF; cfg = 33'd0;
        step();
        reset = 1'b1;
    endtask

    task automatic configure(input logic [31:0] ins, input logic [31:0] k);
        cfg = {1'b1, ins};
        step();
        cfg = {1'b1, k};
        step();
        cfg = 33'd0;
    endtask

    initial begin
        //            op    sa    ub    sb    sh    k             a              la    sendb b              lb    ed             el
        vt[0]  = '{4'd0, 3'd1, 1'b1, 3'd0, 5'd0, 32'd8,        32'd5,         1'b0, 1'b0, 32'd0,         1'b0, 32'd13,        1'b0};
        vt[1]  = '{4'd0, 3'd1, 1'b0, 3'd2, 5'd0, 32'd8,        32'd5,         1'b1, 1'b0, 32'd0,         1'b0, 32'd13,        1'b1};
        vt[2]  = '{4'd0, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hFFFF_FFFF, 1'b0, 1'b1, 32'd2,         1'b0, 32'd1,         1'b0};
        vt[3]  = '{4'd1, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'd3,         1'b0, 1'b1, 32'd5,         1'b1, 32'hFFFF_FFFE, 1'b1};
        vt[4]  = '{4'd2, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'h0001_0000, 1'b0, 1'b1, 32'h0001_0001, 1'b0, MUL_EXP,       1'b0};
        vt[5]  = '{4'd3, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hF0F0,      1'b0, 1'b1, 32'hFF00,      1'b0, 32'hF000,      1'b0};
        vt[6]  = '{4'd4, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hF0F0,      1'b0, 1'b1, 32'h0F0F,      1'b0, 32'hFFFF,      1'b0};
        vt[7]  = '{4'd5, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hFF00_FF00, 1'b0, 1'b1, 32'h0FF0_0FF0, 1'b0, 32'hF0F0_F0F0, 1'b0};
        vt[8]  = '{4'd6, 3'd1, 1'b0, 3'd0, 5'd4, 32'h11,       32'h8000_0001, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_0010, 1'b0};
        vt[9]  = '{4'd7, 3'd1, 1'b0, 3'd0, 5'd4, 32'h11,       32'h8000_0000, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0800_0000, 1'b0};
        vt[10] = '{4'd8, 3'd1, 1'b0, 3'd0, 5'd4, 32'h11,       32'h8000_0000, 1'b0, 1'b0, 32'd0,         1'b0, 32'hF800_0000, 1'b0};
        vt[11] = '{4'd9, 3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'h1234,      1'b0, 1'b1, 32'h99,        1'b1, 32'h1234,      1'b1};
        vt[12] = '{4'd10,3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1,         1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[13] = '{4'd11,3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1,         1'b0, 32'd1,         1'b0};
        vt[14] = '{4'd12,3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'd7,         1'b0, 1'b1, 32'd7,         1'b0, 32'd1,         1'b0};
        vt[15] = '{4'd12,3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'd7,         1'b0, 1'b1, 32'd8,         1'b0, 32'd0,         1'b0};
        vt[16] = '{4'd13,3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'hFFFF_FFFE, 1'b0, 1'b1, 32'd1,         1'b0, 32'd1,         1'b0};
        vt[17] = '{4'd13,3'd1, 1'b1, 3'd2, 5'd0, 32'h11,       32'd5,         1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'd0,         1'b0};
        vt[18] = '{4'd15,3'd1, 1'b0, 3'd0, 5'd0, 32'h11,       32'hABC,       1'b0, 1'b0, 32'd0,         1'b0, 32'hABC,       1'b0};
        vt[19] = '{4'd1, 3'd0, 1'b1, 3'd1, 5'd0, 32'h11,       32'd4,         1'b0, 1'b0, 32'd0,         1'b0, 32'hD,         1'b0};
        vt[20] = '{4'd1, 3'd5, 1'b1, 3'd1, 5'd0, 32'h11,       32'd4,         1'b1, 1'b0, 32'd0,         1'b0, 32'hD,         1'b1};

        // Reset state
        reset = 1'b0;
        in0 = 36'd0; in1 = 36'd0; in2 = 36'd0;
        bus = 4'd0; post = 8'hFF; cfg = 33'd0;
        step();
        step();
        chk("reset_out", out, 36'd0);
        chk("reset_pre", {33'd0, pre2, pre1, pre0}, 36'd7);
        reset = 1'b1;

        // ALU vectors: token in, result two edges later, then consumed to zero
        for (int i = 0; i < 21; i++) begin
            do_reset();
            configure(mk(vt[i].sa, vt[i].ub, vt[i].sh, vt[i].sb, vt[i].op), vt[i].k);
            in0 = tok(vt[i].la, vt[i].a);
            if (vt[i].sendb) in1 = tok(vt[i].lb, vt[i].b);
            step();
            in0 = 36'd0;
            in1 = 36'd0;
            step();
            chk($sformatf("vec%0d", i), out, tok(vt[i].el, vt[i].ed));
            step();
            chk($sformatf("vec%0d_drain", i), out, 36'd0);
        end

        // Backpressure on one consumer
        do_reset();
        configure(mk(3'd1, 1'b0, 5'd0, 3'd0, 4'd0), 32'd8);
        post[3] = 1'b0;
        in0 = tok(1'b0, 32'd1); step();
        in0 = tok(1'b0, 32'd2); step();
        chk("bp_first", out, tok(1'b0, 32'd9));
        in0 = tok(1'b0, 32'd3); step();
        in0 = 36'd0;
        chk("bp_full_ready", {35'd0, pre0}, 36'd0);
        step(); step();
        chk("bp_hold", out, tok(1'b0, 32'd9));
        post[3] = 1'b1;
        step();
        chk("bp_second", out, tok(1'b0, 32'd10));
        chk("bp_ready_back", {35'd0, pre0}, 36'd1);
        step();
        chk("bp_third", out, tok(1'b0, 32'd11));
        step();
        chk("bp_drain", out, 36'd0);

        // Two inputs arriving a cycle apart
        do_reset();
        configure(mk(3'd1, 1'b1, 5'd0, 3'd2, 4'd1), 32'h11);
        in0 = tok(1'b0, 32'd20); step();
        in0 = 36'd0;
        in1 = tok(1'b0, 32'd7);
        chk("sub_wait0", out, 36'd0);
        step();
        in1 = 36'd0;
        chk("sub_wait1", out, 36'd0);
        step();
        chk("sub_result", out, tok(1'b0, 32'd13));

        // Held config words are captured once; constant update timing
        do_reset();
        cfg = {1'b1, mk(3'd1, 1'b0, 5'd0, 3'd0, 4'd0)};
        repeat (5) step();
        cfg = 33'd0;
        in0 = tok(1'b0, 32'd5); step();
        in0 = 36'd0;
        repeat (3) step();
        chk("held_instr_once", out, 36'd0);
        cfg = {1'b1, 32'd8};
        step();
        step();
        chk("const_first", out, tok(1'b0, 32'd13));
        repeat (3) step();
        cfg = 33'd0;
        chk("held_const_idle", out, 36'd0);
        in0 = tok(1'b0, 32'd5); step();
        in0 = 36'd0;
        cfg = {1'b1, 32'd12};
        step();
        cfg = 33'd0;
        chk("const_same_edge", out, tok(1'b0, 32'd13));
        in0 = tok(1'b0, 32'd5); step();
        in0 = 36'd0;
        step();
        chk("const_new", out, tok(1'b0, 32'd17));

        // Global hold fills the FIFO; release drains in order
        do_reset();
        configure(mk(3'd1, 1'b0, 5'd0, 3'd0, 4'd0), 32'd8);
        bus = 4'b0001;
        in0 = tok(1'b0, 32'd1); step();
        in0 = tok(1'b0, 32'd2); step();
        in0 = 36'd0;
        chk("hold_full", {35'd0, pre0}, 36'd0);
        step(); step();
        chk("hold_nofire", out, 36'd0);
        bus = 4'b1110;
        step();
        chk("hold_rel1", out, tok(1'b0, 32'd9));
        chk("hold_ready", {35'd0, pre0}, 36'd1);
        step();
        chk("hold_rel2", out, tok(1'b0, 32'd10));
        step();
        chk("hold_drain", out, 36'd0);

        // Same FIFO for both operands: one pop per firing
        do_reset();
        configure(mk(3'd1, 1'b1, 5'd0, 3'd1, 4'd0), 32'h11);
        in0 = tok(1'b1, 32'd6); step();
        in0 = tok(1'b0, 32'd10); step();
        in0 = 36'd0;
        chk("same_src1", out, tok(1'b1, 32'd12));
        step();
        chk("same_src2", out, tok(1'b0, 32'd20));
        step();
        chk("same_src_drain", out, 36'd0);

        // Reset mid-stream clears tokens and configuration
        do_reset();
        configure(mk(3'd1, 1'b0, 5'd0, 3'd0, 4'd0), 32'd8);
        post[3] = 1'b0;
        in0 = tok(1'b0, 32'd1); step();
        in0 = tok(1'b0, 32'd2); step();
        in0 = tok(1'b0, 32'd3); step();
        in0 = 36'd0;
        chk("pre_rst_out", out, tok(1'b0, 32'd9));
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async_out", out, 36'd0);
        chk("rst_async_pre", {35'd0, pre0}, 36'd1);
        step();
        reset = 1'b1;
        post[3] = 1'b1;
        configure(mk(3'd1, 1'b0, 5'd0, 3'd0, 4'd0), 32'd8);
        repeat (3) step();
        chk("rst_flushed", out, 36'd0);
        in0 = tok(1'b0, 32'd4); step();
        in0 = 36'd0;
        step();
        chk("rst_reconfig", out, tok(1'b0, 32'd12));
        reset = 1'b0;
        step();
        reset = 1'b1;
        in0 = tok(1'b0, 32'd5); step();
        in0 = 36'd0;
        repeat (3) step();
        chk("wait_instr_nofire", out, 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
